// File: rtl/fiat_25519_carry_reduce_seq.sv
// Sequential carry-ripple and *19 fold back end for p = 2^255-19, one limb per beat.
// Optional FIAT_CARRY_STATUS_EN adds loose_ovf, flagging a folded r[1] at or above 2^25.
module fiat_25519_carry_reduce_seq #(
  parameter int LIMBS    = 10,
  parameter int IN_W     = 64,
  parameter int OUT_W    = 32,
  parameter int FOLD_MUL = 19
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef FIAT_CARRY_STATUS_EN
 ,output logic             loose_ovf
`endif
);

  localparam int IDX_W   = 4;
  localparam int LIMB_W  = 26;
  localparam int CARRY_W = IN_W + 1 - 25;
  localparam int T_W     = 48;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LIMBS - 1);
  localparam logic [T_W-1:0] FOLD_K = T_W'(FOLD_MUL);

  typedef enum logic [1:0] {
    LOAD,
    FOLD,
    EMIT
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   idx_inc;
  logic [CARRY_W-1:0] carry_reg;
  logic [CARRY_W-1:0] carry_next;

  // Odd limbs only use the low 25 bits; bit 25 of r[1] can be set after the fold.
  logic [LIMB_W-1:0] limb_reg  [LIMBS];
  logic [LIMB_W-1:0] limb_next [LIMBS];
  logic [LIMBS-1:0]  limb_we;

  logic              load_fire;
  logic              fold_fire;
  logic              emit_fire;

  logic [IN_W:0]     acc;
  logic [LIMB_W-1:0] limb_in;
  logic [T_W-1:0]    fold_prod;
  logic [T_W-1:0]    fold_t;
  logic [LIMB_W-1:0] fold_hi;
  logic [LIMB_W-1:0] r1_sum;

  assign in_ready  = (state_reg == LOAD);
  assign load_fire = (state_reg == LOAD) && in_valid;
  assign fold_fire = (state_reg == FOLD);
  assign emit_fire = (state_reg == EMIT) && out_ready;
  assign idx_inc   = idx_reg + 1'b1;

  // Carry ripple: even limbs are 26 bits, odd limbs 25 bits.
  assign acc        = {1'b0, in_data} + {{(IN_W + 1 - CARRY_W){1'b0}}, carry_reg};
  assign carry_next = idx_reg[0] ? acc[IN_W:25] : {1'b0, acc[IN_W:26]};
  assign limb_in    = idx_reg[0] ? {1'b0, acc[24:0]} : acc[25:0];

  // Fold the carry out of limb 9 into limb 0, spilling anything above 26 bits into limb 1.
  assign fold_prod = {{(T_W - CARRY_W){1'b0}}, carry_reg} * FOLD_K;
  assign fold_t    = {{(T_W - LIMB_W){1'b0}}, limb_reg[0]} + fold_prod;
  assign fold_hi   = LIMB_W'(fold_t[T_W-1:26]);
  assign r1_sum    = limb_reg[1] + fold_hi;

  genvar gi;
  generate
    for (gi = 0; gi < LIMBS; gi++) begin : g_limb
      if (gi == 0) begin : g_fold_lo
        assign limb_we[gi]   = (load_fire && (idx_reg == IDX_W'(gi))) || fold_fire;
        assign limb_next[gi] = fold_fire ? fold_t[LIMB_W-1:0] : limb_in;
      end else if (gi == 1) begin : g_fold_hi
        assign limb_we[gi]   = (load_fire && (idx_reg == IDX_W'(gi))) || fold_fire;
        assign limb_next[gi] = fold_fire ? r1_sum : limb_in;
      end else begin : g_plain
        assign limb_we[gi]   = load_fire && (idx_reg == IDX_W'(gi));
        assign limb_next[gi] = limb_in;
      end
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < LIMBS; i++) begin
      if (ap_rst_n && limb_we[i]) begin
        limb_reg[i] <= limb_next[i];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD: if (in_valid && (idx_reg == LAST)) state_next = FOLD;
      FOLD: state_next = EMIT;
      EMIT: if (out_ready && (idx_reg == LAST)) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Output beat registers: loaded directly from the fold result, then from limb_reg.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx_reg   <= '0;
      carry_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load_fire) begin
        carry_reg <= carry_next;
        idx_reg   <= idx_inc;
      end
      if (fold_fire) begin
        carry_reg <= '0;
        idx_reg   <= '0;
        out_data  <= OUT_W'(fold_t[LIMB_W-1:0]);
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end
      if (emit_fire) begin
        if (idx_reg == LAST) begin
          idx_reg   <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          idx_reg   <= idx_inc;
          out_data  <= OUT_W'(limb_reg[idx_inc]);
          out_last  <= (idx_inc == LAST);
        end
      end
    end
  end

`ifdef FIAT_CARRY_STATUS_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      loose_ovf <= 1'b0;
    end else if (fold_fire) begin
      loose_ovf <= r1_sum[25];
    end else if (emit_fire && (idx_reg == LAST)) begin
      loose_ovf <= 1'b0;
    end
  end
`endif

endmodule
